byte_stream_word_assembler: RTL and testbench
=============================================

# byte_stream_word_assembler

Packs a byte-beat stream from the host load path into wide accelerator words (weights, activations, layer descriptors) with valid/ready handshakes on both sides. It generalises the team's byte-write register: parameterised beat width, word width and byte order, automatic lane indexing, partial-word flush and a one-entry output slot. The output slot lets a full word drain while the next one fills. It sits between the host byte interface and the accelerator's on-chip buffers.

## Interface
- WORD_BYTES, 12, bytes per output word; must be a multiple of BEAT_BYTES
- BEAT_BYTES, 1, bytes accepted per input beat (1, 2, 4 supported)
- BIG_ENDIAN, 0, 0: first byte received lands in byte lane 0; 1: first byte received lands in lane WORD_BYTES-1
- CNT_W, $clog2(WORD_BYTES+1), width of byte counters
- CLK  input  1  clock, all logic on rising edge
- ARESET  input  1  reset, synchronous, active-low
- CLEAR  input  1  synchronous discard of the partially assembled word
- IN_VALID  input  1  beat offered
- IN_READY  output  1  beat accepted when IN_VALID && IN_READY
- IN_DATA  input  BEAT_BYTES*8  beat payload; byte j = IN_DATA[j*8+:8], j=0 is earliest in stream order
- IN_LAST  input  1  qualifies beat; closes the current word after this beat
- OUT_VALID  output  1  word held in output slot
- OUT_READY  input  1  consumer takes word when OUT_VALID && OUT_READY
- OUT_DATA  output  WORD_BYTES*8  assembled word, unfilled lanes zero
- OUT_BYTES  output  CNT_W  number of valid bytes in OUT_DATA (BEAT_BYTES..WORD_BYTES)
- OUT_PARTIAL  output  1  word was closed by IN_LAST before full
- FILL_BYTES  output  CNT_W  bytes currently held in the assembly register

## Operation
- Assembly register asm (WORD_BYTES*8) and fill counter fill (CNT_W); both reset and clear to 0.
- Lane mapping, accepted beat byte j with k = fill+j: LE writes lane k; BE writes lane WORD_BYTES-1-k.
- Accept: IN_VALID && IN_READY. Then fill += BEAT_BYTES, and the beat's lanes are written.
- Word close: the accepted beat makes fill+BEAT_BYTES == WORD_BYTES, or IN_LAST=1. On close:
  - asm with the new beat merged moves to the output slot.
  - OUT_BYTES = fill+BEAT_BYTES; OUT_PARTIAL = (OUT_BYTES != WORD_BYTES).
  - asm and fill return to 0 in the same edge.
- IN_READY = ARESET && !CLEAR && (!OUT_VALID || OUT_READY). This is a combinational path from OUT_READY. It does not depend on IN_LAST or fill.
- Output slot states: EMPTY and FULL.
  - EMPTY -> FULL on word close.
  - FULL -> EMPTY on OUT_READY with no close in the same cycle.
  - FULL -> FULL (reloaded with the new word) on OUT_READY with a close in the same cycle.
  - FULL holds OUT_DATA, OUT_BYTES and OUT_PARTIAL stable until handshake.
- CLEAR: asm and fill go to 0 next edge. IN_READY is low, so no beat is accepted that cycle. The output slot is unaffected and may still drain.
- IN_LAST on a beat that also fills the word gives a normal full word (OUT_PARTIAL=0).
- An empty word is never emitted; IN_LAST always arrives with data.

## Timing
- Reset (ARESET=0 at an edge), after that edge:
  - OUT_VALID=0, OUT_DATA=0, OUT_BYTES=0, OUT_PARTIAL=0, FILL_BYTES=0.
  - IN_READY=0 while ARESET=0.
- Reset dominates CLEAR and handshakes. A reset mid-word discards asm and any slot contents.
- Latency: the closing beat accepted at edge n gives OUT_VALID=1 after edge n (visible in cycle n+1).
- Throughput: one beat per cycle sustained while OUT_READY=1, including back-to-back words.
- With OUT_READY=0 and slot FULL, IN_READY=0. The asm contents are preserved.
- FILL_BYTES is registered and reflects accepted beats up to the last edge.

## Structure
- Package byte_assembler_pkg holds:
  - typedef endian_e (LITTLE, BIG);
  - typedef slot_state_e (EMPTY, FULL);
  - function lane_index(k, WORD_BYTES, BIG_ENDIAN);
  - parameter checks: BEAT_BYTES divides WORD_BYTES; BEAT_BYTES in {1,2,4}.
- Sub-module word_output_slot holds the single-entry register slice: data, byte count, partial flag, valid/ready, and the simultaneous load/drain rule.
- Top level holds asm, fill, lane-merge comb logic and IN_READY.

## Test plan
- WORD_BYTES=12, BEAT_BYTES=1, LE; bytes 0x00..0x0B, OUT_READY=1 -> one word 0x0B0A..0100, OUT_BYTES=12, OUT_PARTIAL=0, OUT_VALID one cycle after byte 0x0B.
- Same stream with BIG_ENDIAN=1 -> OUT_DATA = 0x000102..0A0B (byte 0x00 in lane 11).
- BEAT_BYTES=4, WORD_BYTES=12; beats 0x03020100, 0x07060504 with IN_LAST on the second -> OUT_DATA lanes 0-7 = 0x00..0x07, lanes 8-11 zero, OUT_BYTES=8, OUT_PARTIAL=1.
- Backpressure, 30 bytes streamed, OUT_READY=0 for 20 cycles after the first word closes:
  - IN_READY=0 and FILL_BYTES holds while the slot is full;
  - after release, back-to-back words show no gaps or dropped bytes;
  - order is preserved.
- CLEAR asserted after 5 bytes together with IN_VALID=1 -> beat not accepted, FILL_BYTES=0 next cycle; the next 12 bytes form a clean word.
- ARESET low for one cycle with a full slot and a partial asm -> all outputs 0 next cycle, no word emitted; the next stream assembles from lane 0.

Source files
------------

// File: rtl/byte_assembler_pkg.sv
// Shared types and helpers for the byte-stream word assembler.
// Lane mapping and parameter sanity live here so every unit agrees.
package byte_assembler_pkg;

   typedef enum logic {
      LITTLE = 1'b0,
      BIG    = 1'b1
   } endian_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

   function automatic int unsigned lane_index(
      input int unsigned k,
      input int unsigned word_bytes,
      input logic        big_endian
   );
      return big_endian ? (word_bytes - 1 - k) : k;
   endfunction

   function automatic logic params_ok(
      input int unsigned word_bytes,
      input int unsigned beat_bytes
   );
      logic beat_ok;
      beat_ok = (beat_bytes == 1) || (beat_bytes == 2) ||
                (beat_bytes == 4);
      return beat_ok && (word_bytes >= beat_bytes) &&
             ((word_bytes % beat_bytes) == 0);
   endfunction

endpackage

// File: rtl/word_output_slot.sv
// Single-entry output register slice for assembled words.
// A new word may load in the same cycle the held one drains.
module word_output_slot
   import byte_assembler_pkg::*;
#(
   parameter int WW    = 96,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             ARESET,
   input  logic             load,
   input  logic [WW-1:0]    load_data,
   input  logic [CNT_W-1:0] load_bytes,
   input  logic             load_partial,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WW-1:0]    out_data,
   output logic [CNT_W-1:0] out_bytes,
   output logic             out_partial
);

   localparam logic ST_EMPTY = EMPTY;
   localparam logic ST_FULL  = FULL;

   logic             state_q, state_d;
   logic [WW-1:0]    data_q, data_d;
   logic [CNT_W-1:0] bytes_q, bytes_d;
   logic             partial_q, partial_d;

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      bytes_d   = bytes_q;
      partial_d = partial_q;
      if (load) begin
         state_d   = ST_FULL;
         data_d    = load_data;
         bytes_d   = load_bytes;
         partial_d = load_partial;
      end else if (state_q == ST_FULL && out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge CLK) begin
      if (!ARESET) begin
         state_q   <= ST_EMPTY;
         data_q    <= '0;
         bytes_q   <= '0;
         partial_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         bytes_q   <= bytes_d;
         partial_q <= partial_d;
      end
   end

   assign out_valid   = (state_q == ST_FULL);
   assign out_data    = data_q;
   assign out_bytes   = bytes_q;
   assign out_partial = partial_q;

endmodule

// File: rtl/byte_stream_word_assembler.sv
// Packs byte beats from the host load path into wide words,
// with partial-word flush on IN_LAST and a one-entry output slot.
module byte_stream_word_assembler
   import byte_assembler_pkg::*;
#(
   parameter int WORD_BYTES = 12,
   parameter int BEAT_BYTES = 1,
   parameter bit BIG_ENDIAN = 1'b0,
   parameter int CNT_W      = $clog2(WORD_BYTES + 1)
) (
   input  logic                    CLK,
   input  logic                    ARESET,
   input  logic                    CLEAR,
   input  logic                    IN_VALID,
   output logic                    IN_READY,
   input  logic [BEAT_BYTES*8-1:0] IN_DATA,
   input  logic                    IN_LAST,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY,
   output logic [WORD_BYTES*8-1:0] OUT_DATA,
   output logic [CNT_W-1:0]        OUT_BYTES,
   output logic                    OUT_PARTIAL,
   output logic [CNT_W-1:0]        FILL_BYTES
);

   localparam int WW = WORD_BYTES * 8;
   localparam endian_e ORDER = BIG_ENDIAN ? BIG : LITTLE;

   generate
      if (!params_ok(WORD_BYTES, BEAT_BYTES)) begin : g_bad_params
         $error("unsupported WORD_BYTES/BEAT_BYTES");
      end
   endgenerate

   logic [WW-1:0]    asm_q, asm_d, merged;
   logic [CNT_W-1:0] fill_q, fill_d, next_fill;
   logic             accept, close, slot_valid;

   // Ready only looks at the slot, never at the word being built.
   assign IN_READY  = ARESET && !CLEAR && (!slot_valid || OUT_READY);
   assign accept    = IN_VALID && IN_READY;
   assign next_fill = fill_q + CNT_W'(BEAT_BYTES);
   assign close     = accept &&
                      (next_fill == CNT_W'(WORD_BYTES) || IN_LAST);

   always_comb begin
      merged = asm_q;
      for (int l = 0; l < WORD_BYTES; l++) begin
         for (int j = 0; j < BEAT_BYTES; j++) begin
            if (lane_index(32'(fill_q) + j, WORD_BYTES,
                           ORDER == BIG) == l) begin
               merged[l*8 +: 8] = IN_DATA[j*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      asm_d  = asm_q;
      fill_d = fill_q;
      if (CLEAR || close) begin
         asm_d  = '0;
         fill_d = '0;
      end else if (accept) begin
         asm_d  = merged;
         fill_d = next_fill;
      end
   end

   always_ff @(posedge CLK) begin
      if (!ARESET) begin
         asm_q  <= '0;
         fill_q <= '0;
      end else begin
         asm_q  <= asm_d;
         fill_q <= fill_d;
      end
   end

   word_output_slot #(
      .WW    (WW),
      .CNT_W (CNT_W)
   ) u_slot (
      .CLK          (CLK),
      .ARESET       (ARESET),
      .load         (close),
      .load_data    (merged),
      .load_bytes   (next_fill),
      .load_partial (next_fill != CNT_W'(WORD_BYTES)),
      .out_ready    (OUT_READY),
      .out_valid    (slot_valid),
      .out_data     (OUT_DATA),
      .out_bytes    (OUT_BYTES),
      .out_partial  (OUT_PARTIAL)
   );

   assign OUT_VALID  = slot_valid;
   assign FILL_BYTES = fill_q;

endmodule

// File: tb/tb_byte_stream_word_assembler.sv
// Directed bench for byte_stream_word_assembler: LE, BE and
// 4-byte-beat instances driven by per-scenario tasks.
module tb_byte_stream_word_assembler;

   typedef struct packed {
      logic [95:0] d;
      logic [3:0]  b;
      logic        p;
   } word_t;

   logic CLK;
   logic arst_n, clr, iv, ilast, ordy;
   logic [7:0] idat;
   logic clr4, iv4, ilast4, ordy4;
   logic [31:0] idat4;

   logic le_ir, le_ov, le_op;
   logic [95:0] le_od;
   logic [3:0] le_ob, le_fill;
   logic be_ir, be_ov, be_op;
   logic [95:0] be_od;
   logic [3:0] be_ob, be_fill;
   logic w4_ir, w4_ov, w4_op;
   logic [95:0] w4_od;
   logic [3:0] w4_ob, w4_fill;

   int errors = 0;
   int checks = 0;
   word_t q[$];

   byte_stream_word_assembler #(
      .WORD_BYTES(12), .BEAT_BYTES(1), .BIG_ENDIAN(1'b0)
   ) u_le (
      .CLK(CLK), .ARESET(arst_n), .CLEAR(clr),
      .IN_VALID(iv), .IN_READY(le_ir), .IN_DATA(idat),
      .IN_LAST(ilast), .OUT_VALID(le_ov), .OUT_READY(ordy),
      .OUT_DATA(le_od), .OUT_BYTES(le_ob),
      .OUT_PARTIAL(le_op), .FILL_BYTES(le_fill)
   );

   byte_stream_word_assembler #(
      .WORD_BYTES(12), .BEAT_BYTES(1), .BIG_ENDIAN(1'b1)
   ) u_be (
      .CLK(CLK), .ARESET(arst_n), .CLEAR(clr),
      .IN_VALID(iv), .IN_READY(be_ir), .IN_DATA(idat),
      .IN_LAST(ilast), .OUT_VALID(be_ov), .OUT_READY(ordy),
      .OUT_DATA(be_od), .OUT_BYTES(be_ob),
      .OUT_PARTIAL(be_op), .FILL_BYTES(be_fill)
   );

   byte_stream_word_assembler #(
      .WORD_BYTES(12), .BEAT_BYTES(4), .BIG_ENDIAN(1'b0)
   ) u_w4 (
      .CLK(CLK), .ARESET(arst_n), .CLEAR(clr4),
      .IN_VALID(iv4), .IN_READY(w4_ir), .IN_DATA(idat4),
      .IN_LAST(ilast4), .OUT_VALID(w4_ov), .OUT_READY(ordy4),
      .OUT_DATA(w4_od), .OUT_BYTES(w4_ob),
      .OUT_PARTIAL(w4_op), .FILL_BYTES(w4_fill)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (arst_n && le_ov && ordy)
         q.push_back('{le_od, le_ob, le_op});
   end

   function automatic logic [95:0] seq_word(
      input logic [7:0] base, input int n);
      logic [95:0] w;
      w = '0;
      for (int b = 0; b < n; b++)
         w[b*8 +: 8] = base + 8'(b);
      return w;
   endfunction

   task automatic feed(input int n, input logic [7:0] base,
                       input bit last_end);
      for (int i = 0; i < n; i++) begin
         int waits;
         bit acc;
         waits = 0;
         acc = 1'b0;
         iv = 1'b1;
         idat = base + 8'(i);
         ilast = last_end && (i == n - 1);
         while (!acc) begin
            @(negedge CLK);
            acc = le_ir;
            @(posedge CLK); #1;
            waits++;
            if (!acc && waits > 200) begin
               checks++; errors++;
               $display("FAIL feed_timeout byte %0d not accepted", i);
               iv = 1'b0; ilast = 1'b0;
               return;
            end
         end
      end
      iv = 1'b0;
      ilast = 1'b0;
   endtask

   task automatic test_reset();
      arst_n = 1'b0; clr = 1'b0; iv = 1'b0; ilast = 1'b0;
      ordy = 1'b0; idat = '0;
      clr4 = 1'b0; iv4 = 1'b0; ilast4 = 1'b0; ordy4 = 1'b0;
      idat4 = '0;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (le_ov !== 1'b0) begin errors++;
         $display("FAIL rst_ov got %b want 0", le_ov); end
      checks++;
      if (le_od !== 96'h0) begin errors++;
         $display("FAIL rst_od got %h want 0", le_od); end
      checks++;
      if (le_ob !== 4'd0 || le_op !== 1'b0) begin errors++;
         $display("FAIL rst_ob_op got %0d/%b want 0/0",
                  le_ob, le_op); end
      checks++;
      if (le_fill !== 4'd0) begin errors++;
         $display("FAIL rst_fill got %0d want 0", le_fill); end
      checks++;
      if (le_ir !== 1'b0 || w4_ir !== 1'b0) begin errors++;
         $display("FAIL rst_ir got %b/%b want 0/0", le_ir, w4_ir); end
      arst_n = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_le_be_full();
      ordy = 1'b1;
      q.delete();
      feed(11, 8'h00, 1'b0);
      checks++;
      if (le_ov !== 1'b0 || le_fill !== 4'd11) begin errors++;
         $display("FAIL pre_close ov/fill got %b/%0d want 0/11",
                  le_ov, le_fill); end
      feed(1, 8'h0B, 1'b0);
      checks++;
      if (le_ov !== 1'b1) begin errors++;
         $display("FAIL latency ov got %b want 1", le_ov); end
      checks++;
      if (le_od !== 96'h0B0A09080706050403020100) begin errors++;
         $display("FAIL le_word got %h want 0b0a..0100", le_od); end
      checks++;
      if (le_ob !== 4'd12 || le_op !== 1'b0) begin errors++;
         $display("FAIL le_bytes got %0d/%b want 12/0",
                  le_ob, le_op); end
      checks++;
      if (be_od !== 96'h000102030405060708090A0B) begin errors++;
         $display("FAIL be_word got %h want 0001..0a0b", be_od); end
      checks++;
      if (le_fill !== 4'd0) begin errors++;
         $display("FAIL post_close fill got %0d want 0", le_fill); end
      @(posedge CLK); #1;
      checks++;
      if (le_ov !== 1'b0) begin errors++;
         $display("FAIL drain ov got %b want 0", le_ov); end
   endtask

   task automatic test_beat4();
      ordy4 = 1'b1;
      iv4 = 1'b1; idat4 = 32'h03020100; ilast4 = 1'b0;
      @(negedge CLK);
      checks++;
      if (w4_ir !== 1'b1) begin errors++;
         $display("FAIL w4_ready got %b want 1", w4_ir); end
      @(posedge CLK); #1;
      idat4 = 32'h07060504; ilast4 = 1'b1;
      @(posedge CLK); #1;
      iv4 = 1'b0; ilast4 = 1'b0;
      checks++;
      if (w4_ov !== 1'b1 ||
          w4_od !== 96'h000000000706050403020100) begin errors++;
         $display("FAIL w4_partial_word got %b/%h want 1/..0100",
                  w4_ov, w4_od); end
      checks++;
      if (w4_ob !== 4'd8 || w4_op !== 1'b1) begin errors++;
         $display("FAIL w4_partial_meta got %0d/%b want 8/1",
                  w4_ob, w4_op); end
      iv4 = 1'b1; idat4 = 32'h13121110;
      @(posedge CLK); #1;
      idat4 = 32'h17161514;
      @(posedge CLK); #1;
      idat4 = 32'h1B1A1918; ilast4 = 1'b1;
      @(posedge CLK); #1;
      iv4 = 1'b0; ilast4 = 1'b0;
      checks++;
      if (w4_od !== 96'h1B1A191817161514_13121110 ||
          w4_ob !== 4'd12 || w4_op !== 1'b0) begin errors++;
         $display("FAIL w4_last_full got %h/%0d/%b want full/12/0",
                  w4_od, w4_ob, w4_op); end
      @(posedge CLK); #1;
   endtask

   task automatic test_back_to_back();
      bit done;
      int f0, bad, n, w;
      done = 1'b0; bad = 0; n = 0; w = 0; f0 = 0;
      ordy = 1'b1;
      q.delete();
      fork
         begin
            feed(30, 8'h10, 1'b1);
            done = 1'b1;
         end
         begin
            while (le_ov !== 1'b1 && w < 100) begin
               @(posedge CLK); #2;
               w++;
            end
            ordy = 1'b0;
            f0 = int'(le_fill);
            repeat (20) begin
               @(negedge CLK);
               if (le_ir !== 1'b0 || int'(le_fill) != f0 ||
                   le_ov !== 1'b1) bad++;
            end
            @(posedge CLK); #2;
            ordy = 1'b1;
            while (!done && n < 100) begin
               @(posedge CLK); #3;
               n++;
            end
            repeat (3) @(posedge CLK);
            #1;
         end
      join
      checks++;
      if (bad != 0 || f0 != 0) begin errors++;
         $display("FAIL stall bad=%0d fill=%0d want 0/0", bad, f0); end
      checks++;
      if (n != 18) begin errors++;
         $display("FAIL no_gaps cycles got %0d want 18", n); end
      checks++;
      if (q.size() != 3) begin errors++;
         $display("FAIL word_count got %0d want 3", q.size());
      end else begin
         checks++;
         if (q[0].d !== seq_word(8'h10, 12) || q[0].p !== 1'b0)
         begin errors++;
            $display("FAIL bp_word0 got %h want %h",
                     q[0].d, seq_word(8'h10, 12)); end
         checks++;
         if (q[1].d !== seq_word(8'h1C, 12) || q[1].b !== 4'd12)
         begin errors++;
            $display("FAIL bp_word1 got %h want %h",
                     q[1].d, seq_word(8'h1C, 12)); end
         checks++;
         if (q[2].d !== seq_word(8'h28, 6) || q[2].b !== 4'd6 ||
             q[2].p !== 1'b1) begin errors++;
            $display("FAIL bp_word2 got %h/%0d/%b want %h/6/1",
                     q[2].d, q[2].b, q[2].p, seq_word(8'h28, 6)); end
      end
   endtask

   task automatic test_clear();
      ordy = 1'b1;
      q.delete();
      feed(5, 8'h40, 1'b0);
      clr = 1'b1; iv = 1'b1; idat = 8'hEE;
      @(negedge CLK);
      checks++;
      if (le_ir !== 1'b0) begin errors++;
         $display("FAIL clear_ready got %b want 0", le_ir); end
      @(posedge CLK); #1;
      clr = 1'b0; iv = 1'b0;
      checks++;
      if (le_fill !== 4'd0) begin errors++;
         $display("FAIL clear_fill got %0d want 0", le_fill); end
      feed(12, 8'h50, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (q.size() != 1) begin errors++;
         $display("FAIL clear_count got %0d want 1", q.size());
      end else if (q[0].d !== seq_word(8'h50, 12) ||
                   q[0].p !== 1'b0) begin
         errors++;
         $display("FAIL clear_word got %h want %h",
                  q[0].d, seq_word(8'h50, 12));
      end
   endtask

   task automatic test_reset_mid();
      ordy = 1'b0;
      q.delete();
      feed(12, 8'h60, 1'b0);
      checks++;
      if (le_ov !== 1'b1) begin errors++;
         $display("FAIL held_ov got %b want 1", le_ov); end
      arst_n = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (le_ov !== 1'b0 || le_od !== 96'h0 || le_ob !== 4'd0 ||
          le_op !== 1'b0 || le_ir !== 1'b0) begin errors++;
         $display("FAIL midrst got ov%b od%h ob%0d op%b ir%b want 0",
                  le_ov, le_od, le_ob, le_op, le_ir); end
      arst_n = 1'b1;
      @(posedge CLK); #1;
      feed(5, 8'h70, 1'b0);
      arst_n = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (le_fill !== 4'd0) begin errors++;
         $display("FAIL midrst_fill got %0d want 0", le_fill); end
      arst_n = 1'b1;
      ordy = 1'b1;
      feed(12, 8'h80, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (q.size() != 1) begin errors++;
         $display("FAIL midrst_count got %0d want 1", q.size());
      end else if (q[0].d !== seq_word(8'h80, 12)) begin
         errors++;
         $display("FAIL midrst_word got %h want %h",
                  q[0].d, seq_word(8'h80, 12));
      end
   endtask

   initial begin
      test_reset();
      test_le_be_full();
      test_beat4();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
